// File: rtl/lmem_stream_reader_if.sv
// Bundle between the LMEM stream reader, its LMEM read port and the stream consumer.
// slave = the reader itself; master = the surrounding system (LMEM + consumer + control).
interface lmem_stream_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [LEN_WIDTH-1:0]  len;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] raddr_0;
  logic [DATA_WIDTH-1:0] q_0;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport slave (
    input  start,
    input  base_addr,
    input  len,
    input  q_0,
    input  out_ready,
    output busy,
    output done,
    output raddr_0,
    output out_data,
    output out_valid
  );

  modport master (
    output start,
    output base_addr,
    output len,
    output q_0,
    output out_ready,
    input  busy,
    input  done,
    input  raddr_0,
    input  out_data,
    input  out_valid
  );
endinterface

// File: rtl/lmem_stream_reader.sv
// Walks an LMEM address range and turns the registered read data into a
// valid/ready stream, absorbing the one-cycle read latency in a 2-entry buffer.
module lmem_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  lmem_stream_reader_if.slave  bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic [LEN_WIDTH-1:0]  r_rem;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_buf [2];
  logic                  r_head;
  logic [1:0]            r_cnt;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_issue;
  logic                  w_start;
  logic                  w_drained;
  logic                  w_tail;
  logic [1:0]            w_occ;

  assign w_pop   = (r_cnt != 2'd0) & bus.out_ready;
  assign w_push  = r_inflight;
  // occupancy at end of cycle; a read issued now lands one cycle later
  assign w_occ   = r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
  assign w_issue = (r_state == S_RUN) & (r_rem != '0) & (w_occ < 2'd2);
  assign w_start = (r_state == S_IDLE) & bus.start;
  assign w_tail  = r_head ^ r_cnt[0];
  assign w_drained = ~r_inflight & (r_cnt == 2'd1) & w_pop;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start)
          w_state_nxt = (bus.len == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (w_issue && (r_rem == LEN_WIDTH'(1)))
          w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_drained)
          w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_raddr    <= '0;
      r_rem      <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_issue;
      if (w_start) begin
        r_addr <= bus.base_addr;
        r_rem  <= bus.len;
      end else if (w_issue) begin
        r_addr  <= r_addr + ADDR_WIDTH'(1);
        r_rem   <= r_rem - LEN_WIDTH'(1);
        r_raddr <= r_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_buf[0] <= '0;
      r_buf[1] <= '0;
      r_head   <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push)
        r_buf[w_tail] <= bus.q_0;
      if (w_pop)
        r_head <= ~r_head;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign bus.raddr_0   = w_issue ? r_addr : r_raddr;
  assign bus.out_data  = r_buf[r_head];
  assign bus.out_valid = (r_cnt != 2'd0);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
endmodule

// File: tb/tb_lmem_stream_reader.sv
// Scoreboard bench for lmem_stream_reader with a registered-read LMEM model.
// Expected words are queued at stimulus time; a negedge monitor pops on handshakes.
module tb_lmem_stream_reader;
  localparam int DW = 8;
  localparam int AW = 6;
  localparam int LW = AW + 1;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  lmem_stream_reader_if #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)
  ) bus ();

  lmem_stream_reader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [64];
  always @(posedge clk) bus.q_0 <= ram[bus.raddr_0];

  logic rnd_en  = 1'b0;
  logic rnd_r   = 1'b0;
  logic rdy_fix = 1'b1;
  always @(posedge clk) rnd_r <= 1'($urandom_range(0, 1));
  assign bus.out_ready = rnd_en ? rnd_r : rdy_fix;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  logic [DW-1:0] exp_q [$];
  logic          pv_stall = 1'b0;
  logic [DW-1:0] pdata    = '0;

  always @(negedge clk) begin
    if (!rstn) begin
      pv_stall <= 1'b0;
    end else begin
      if (pv_stall) begin
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_data", 32'(bus.out_data), 32'(pdata));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word got=%0h want=none", bus.out_data);
        end else begin
          chk("data", 32'(bus.out_data), 32'(exp_q.pop_front()));
        end
      end
      pv_stall <= bus.out_valid && !bus.out_ready;
      pdata    <= bus.out_data;
    end
  end

  int base_cur = 0;
  int len_cur  = 0;
  logic [AW-1:0] trace [1:8];

  task automatic set_rdy(input logic fix, input logic rnd);
    @(posedge clk);
    #1;
    rdy_fix = fix;
    rnd_en  = rnd;
  endtask

  task automatic go(input int b, input int l);
    @(posedge clk);
    #1;
    bus.start     = 1'b1;
    bus.base_addr = AW'(b);
    bus.len       = LW'(l);
    base_cur      = b;
    len_cur       = l;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic run(input int budget, input int poke_n,
                     output int fv, output int dn);
    int n = 0;
    int hs = 0;
    logic [AW-1:0] rel;
    fv = -1;
    dn = -1;
    while (dn < 0 && n < budget) begin
      @(negedge clk);
      n++;
      if (n <= 8) trace[n] = bus.raddr_0;
      if (fv < 0 && bus.out_valid) fv = n;
      if (bus.done) dn = n;
      if (bus.busy && len_cur != 0) begin
        rel = bus.raddr_0 - AW'(base_cur);
        chk("raddr_ahead", 32'((int'(rel) - hs) <= 2), 32'd1);
      end
      if (bus.out_valid && bus.out_ready) hs++;
      bus.start = (n == poke_n);
      if (n == poke_n) begin
        bus.base_addr = 6'd20;
        bus.len       = 7'd5;
      end
    end
    bus.start = 1'b0;
    if (dn < 0) begin
      checks++;
      errors++;
      $display("FAIL timeout got=no_done want=done within %0d", budget);
    end else begin
      @(negedge clk);
      chk("done_1cyc", 32'(bus.done), 32'd0);
      chk("idle_busy", 32'(bus.busy), 32'd0);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_data"}, 32'(bus.out_data), 32'd0);
    chk({tag, "_raddr"}, 32'(bus.raddr_0), 32'd0);
  endtask

  initial begin
    int fv;
    int dn;
    logic [AW-1:0] r0;
    for (int i = 0; i < 64; i++) ram[i] = 8'(i + 16);
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.len       = '0;
    #12;
    chk_zero("rst");
    rstn = 1'b1;

    // basic: base 4, len 3
    exp_q.push_back(8'h14);
    exp_q.push_back(8'h15);
    exp_q.push_back(8'h16);
    go(4, 3);
    run(30, 0, fv, dn);
    chk("t1_first_valid", 32'(fv - 1), 32'd2);
    chk("t1_done_lat", 32'(dn - 1), 32'd5);
    chk("t1_raddr", 32'(trace[1]), 32'd4);
    chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // address wrap
    exp_q.push_back(8'h4E);
    exp_q.push_back(8'h4F);
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h11);
    go(62, 4);
    run(30, 0, fv, dn);
    chk("t2_raddr1", 32'(trace[1]), 32'd62);
    chk("t2_raddr2", 32'(trace[2]), 32'd63);
    chk("t2_raddr3", 32'(trace[3]), 32'd0);
    chk("t2_raddr4", 32'(trace[4]), 32'd1);
    chk("t2_done_lat", 32'(dn - 1), 32'd6);
    chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // backpressure: stall then random ready
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(8'h10 + i));
    set_rdy(1'b0, 1'b0);
    go(0, 8);
    repeat (5) @(negedge clk);
    chk("t3_stall_raddr", 32'(bus.raddr_0), 32'd1);
    chk("t3_stall_valid", 32'(bus.out_valid), 32'd1);
    chk("t3_stall_data", 32'(bus.out_data), 32'h10);
    set_rdy(1'b0, 1'b1);
    run(400, 0, fv, dn);
    set_rdy(1'b1, 1'b0);
    chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // zero length
    r0 = bus.raddr_0;
    go(33, 0);
    run(10, 0, fv, dn);
    chk("t4_no_valid", 32'(fv), 32'hFFFF_FFFF);
    chk("t4_done_lat", 32'(dn), 32'd1);
    chk("t4_raddr_hold", 32'(bus.raddr_0), 32'(r0));

    // start while busy is ignored
    for (int i = 0; i < 6; i++) exp_q.push_back(8'(8'h10 + i));
    go(0, 6);
    run(30, 3, fv, dn);
    chk("t5_done_lat", 32'(dn - 1), 32'd8);
    chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);

    // reset mid-transfer
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(8'h10 + i));
    set_rdy(1'b0, 1'b0);
    go(0, 8);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk_zero("mid_rst");
    exp_q.delete();
    @(negedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    set_rdy(1'b1, 1'b0);
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h11);
    go(0, 2);
    run(20, 0, fv, dn);
    chk("t5r_done_lat", 32'(dn - 1), 32'd4);
    chk("t5r_sb_empty", 32'(exp_q.size()), 32'd0);

    // full sweep from base 5
    for (int i = 0; i < 64; i++) exp_q.push_back(8'(((5 + i) % 64) + 16));
    go(5, 64);
    run(200, 0, fv, dn);
    chk("t6_first_valid", 32'(fv - 1), 32'd2);
    chk("t6_done_lat", 32'(dn - 1), 32'd66);
    chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
